// File: rtl/shift_sequencer.sv
// Multi-cycle barrel shifter: one binary stage (16/8/4/2/1) per SHIFT cycle.
// Optional macro SHIFT_EARLY_EXIT_EN skips stages whose shamt bit is clear.
module shift_sequencer (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] data_in,
    input  logic [4:0]  shamt,
    output logic [31:0] data_result,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state_reg, state_next;
    logic [31:0] data_next;
    logic [4:0]  shamt_reg, shamt_next;
    logic        op_reg, op_next;
    logic [2:0]  stage_reg, stage_next;

    // sel_bits[i] is the shamt bit consumed by stage i (stage 0 = distance 16)
    logic [4:0]  sel_bits;
    logic [31:0] stage_out [5];

    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_stage
            localparam int DIST = 16 >> gi;
            logic signed [31:0] asr_val;
            logic        [31:0] lsl_val;
            // Kept as separate nets so the arithmetic shift stays in signed context
            assign asr_val       = $signed(data_result) >>> DIST;
            assign lsl_val       = data_result << DIST;
            assign sel_bits[gi]  = shamt_reg[4-gi];
            assign stage_out[gi] = op_reg ? asr_val : lsl_val;
        end
    endgenerate

`ifdef SHIFT_EARLY_EXIT_EN
    logic [4:0] start_bits;
    logic [4:0] above_mask;
    logic [3:0] first_start;
    logic [3:0] first_next;

    // Returns {found, index} of the lowest-numbered set stage.
    function automatic logic [3:0] first_set(input logic [4:0] bits);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 4; i >= 0; i--) begin
            if (bits[i]) r = {1'b1, 3'(i)};
        end
        return r;
    endfunction

    assign start_bits  = {shamt[0], shamt[1], shamt[2], shamt[3], shamt[4]};
    assign above_mask  = 5'b11111 << (stage_reg + 3'd1);
    assign first_start = first_set(start_bits);
    assign first_next  = first_set(sel_bits & above_mask);
`endif

    always_comb begin
        state_next = state_reg;
        data_next  = data_result;
        shamt_next = shamt_reg;
        op_next    = op_reg;
        stage_next = stage_reg;
        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    data_next  = data_in;
                    shamt_next = shamt;
                    op_next    = op;
                    stage_next = 3'd0;
                    state_next = SHIFT;
`ifdef SHIFT_EARLY_EXIT_EN
                    if (first_start[3]) stage_next = first_start[2:0];
                    else                state_next = DONE;
`endif
                end else if (state_reg == DONE) begin
                    state_next = IDLE;
                end
            end
            SHIFT: begin
                if (sel_bits[stage_reg]) data_next = stage_out[stage_reg];
`ifdef SHIFT_EARLY_EXIT_EN
                if (first_next[3]) stage_next = first_next[2:0];
                else               state_next = DONE;
`else
                if (stage_reg == 3'd4) state_next = DONE;
                else                   stage_next = stage_reg + 3'd1;
`endif
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg   <= IDLE;
            data_result <= 32'd0;
            shamt_reg   <= 5'd0;
            op_reg      <= 1'b0;
            stage_reg   <= 3'd0;
        end else begin
            state_reg   <= state_next;
            data_result <= data_next;
            shamt_reg   <= shamt_next;
            op_reg      <= op_next;
            stage_reg   <= stage_next;
        end
    end

    assign busy = (state_reg == SHIFT);
    assign done = (state_reg == DONE);

endmodule

// File: tb/tb_shift_sequencer.sv
// Randomized self-checking bench for shift_sequencer against a plain-arithmetic model.
// Honours SHIFT_EARLY_EXIT_EN for the expected latency.
module tb_shift_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        op;
    logic [31:0] data_in;
    logic [4:0]  shamt;
    logic [31:0] data_result;
    logic        busy;
    logic        done;

    int tests_run = 0;
    int tests_failed = 0;

    shift_sequencer dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .data_in     (data_in),
        .shamt       (shamt),
        .data_result (data_result),
        .busy        (busy),
        .done        (done)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_result(input logic o, input logic [31:0] d, input logic [4:0] s);
        logic signed [31:0] sd;
        logic signed [31:0] r;
        sd = d;
        r = sd >>> s;
        return o ? 32'(r) : (d << s);
    endfunction

    function automatic int model_latency(input logic [4:0] s);
`ifdef SHIFT_EARLY_EXIT_EN
        return $countones(s);
`else
        return 5;
`endif
    endfunction

    // Caller has start=1 with operands applied, away from the clock edge.
    task automatic do_op(input logic o, input logic [31:0] d, input logic [4:0] s,
                         input bit mid, input bit chain,
                         input logic no, input logic [31:0] nd, input logic [4:0] ns);
        logic [31:0] exp;
        int lat;
        exp = model_result(o, d, s);
        lat = model_latency(s);
        @(posedge clock); #1;
        for (int k = 0; k <= lat; k++) begin
            if (k > 0) begin
                @(posedge clock); #1;
            end
            if (k < lat) begin
                check_eq("busy_in_shift", 32'(busy), 32'd1);
                check_eq("done_in_shift", 32'(done), 32'd0);
                if (mid && k == 0) begin
                    start   = 1'b1;
                    op      = ~o;
                    data_in = $urandom;
                    shamt   = 5'($urandom_range(0, 31));
                end else begin
                    start = 1'b0;
                end
            end else begin
                check_eq("done_pulse", 32'(done), 32'd1);
                check_eq("busy_at_done", 32'(busy), 32'd0);
                check_eq("result", data_result, exp);
                $display("[TB] op=%0d data=%h shamt=%0d lat=%0d result=%h expected=%h",
                         o, d, s, lat, data_result, exp);
            end
        end
        if (chain) begin
            start   = 1'b1;
            op      = no;
            data_in = nd;
            shamt   = ns;
        end else begin
            start = 1'b0;
            @(posedge clock); #1;
            check_eq("done_cleared", 32'(done), 32'd0);
            check_eq("busy_idle", 32'(busy), 32'd0);
            check_eq("result_held", data_result, exp);
        end
    endtask

    task automatic launch(input logic o, input logic [31:0] d, input logic [4:0] s);
        start   = 1'b1;
        op      = o;
        data_in = d;
        shamt   = s;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic        o, no;
        logic [31:0] d, nd;
        logic [4:0]  s, ns;
        bit          chain;

        // Reset overrides a simultaneous start
        reset = 1'b1; start = 1'b1; op = 1'b1; data_in = 32'hDEAD_BEEF; shamt = 5'd3;
        @(posedge clock); @(posedge clock); #1;
        check_eq("reset_result", data_result, 32'd0);
        check_eq("reset_busy", 32'(busy), 32'd0);
        check_eq("reset_done", 32'(done), 32'd0);
        reset = 1'b0; start = 1'b0;
        @(posedge clock); #1;

        // Directed corner cases
        launch(1'b0, 32'h0000_0001, 5'd31);
        do_op(1'b0, 32'h0000_0001, 5'd31, 0, 0, 0, 0, 0);
        launch(1'b1, 32'h8000_0000, 5'd16);
        do_op(1'b1, 32'h8000_0000, 5'd16, 0, 0, 0, 0, 0);
        launch(1'b1, 32'h7FFF_0000, 5'd4);
        do_op(1'b1, 32'h7FFF_0000, 5'd4, 1, 0, 0, 0, 0);
        launch(1'b0, 32'h1234_5678, 5'd0);
        do_op(1'b0, 32'h1234_5678, 5'd0, 0, 0, 0, 0, 0);
        launch(1'b1, 32'h8765_4321, 5'd0);
        do_op(1'b1, 32'h8765_4321, 5'd0, 0, 0, 0, 0, 0);

        // Back-to-back: start held through DONE with new operands
        launch(1'b0, 32'hA5A5_5A5A, 5'd7);
        do_op(1'b0, 32'hA5A5_5A5A, 5'd7, 0, 1, 1'b1, 32'hF000_000F, 5'd9);
        do_op(1'b1, 32'hF000_000F, 5'd9, 0, 0, 0, 0, 0);

        // Reset in the middle of SHIFT aborts without a done pulse
        launch(1'b0, 32'hCAFE_F00D, 5'd31);
        @(posedge clock); #1;
        start = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check_eq("abort_result", data_result, 32'd0);
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_done", 32'(done), 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(posedge clock); #1;
            check_eq("abort_no_done", 32'(done), 32'd0);
        end
        $display("[TB] reset abort during SHIFT");
        launch(1'b1, 32'hCAFE_F00D, 5'd13);
        do_op(1'b1, 32'hCAFE_F00D, 5'd13, 0, 0, 0, 0, 0);

        // Random operations, some chained back-to-back
        o = 1'($urandom_range(0, 1)); d = $urandom; s = 5'($urandom_range(0, 31));
        launch(o, d, s);
        for (int i = 0; i < 30; i++) begin
            no = 1'($urandom_range(0, 1));
            nd = $urandom;
            ns = 5'($urandom_range(0, 31));
            chain = (i < 29) && ($urandom_range(0, 1) == 1);
            do_op(o, d, s, 0, chain, no, nd, ns);
            o = no; d = nd; s = ns;
            if (!chain && i < 29) launch(o, d, s);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
